sobel_byte_packer: RTL and testbench

Downstream consumer of `image_process_top`: takes the 1-bit Sobel edge stream (`sobel`, `sobel_valid`, `sobel_hsync`, `sobel_vsync`) and packs 8 consecutive pixels into bytes, MSB-first. Packed bytes carry line and frame markers and are buffered in a small FIFO behind a valid/ready interface for a byte-oriented sink such as a UART or a frame-buffer writer. It also counts edge pixels per frame and flags FIFO overflow.

---
 rtl/image_process_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 49 ++++
 rtl/sobel_byte_packer.sv | 126 ++++++++++++
 tb/tb_sobel_byte_packer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/image_process_pkg.sv
// image_process_pkg: shared FIFO entry layout and sizing helpers for the Sobel byte path
package image_process_pkg;

    localparam int ENTRY_BITS = 11;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic       eof;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic int bytes_per_line(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int pix_count_bits(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with full/empty flags and occupancy
module sync_fifo_fwft #(
    parameter int WIDTH_BITS = 11,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_p,
    input  logic                    wr_en,
    input  logic [WIDTH_BITS-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [WIDTH_BITS-1:0]   rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic                  do_wr, do_rd;

    // A write while full only lands when the head is popped in the same cycle
    always_comb begin
        full    = count == (AW + 1)'(DEPTH);
        empty   = count == '0;
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        rd_data = empty ? '0 : mem[rptr];
    end

    // Storage array, no reset needed since empty masks the head
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
        end
    end

endmodule

// File: rtl/sobel_byte_packer.sv
// sobel_byte_packer: packs the 1-bit Sobel stream MSB-first into marked bytes behind a FIFO
module sobel_byte_packer
    import image_process_pkg::*;
#(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 200,
    parameter int DEPTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_p,
    input  logic                                   sobel,
    input  logic                                   sobel_valid,
    input  logic                                   sobel_hsync,
    input  logic                                   sobel_vsync,
    output logic [7:0]                             out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_sof,
    output logic                                   out_eol,
    output logic                                   out_eof,
    output logic                                   overflow,
    output logic [pix_count_bits(WIDTH,HEIGHT)-1:0] edge_count,
    output logic                                   edge_count_valid
);
    localparam int CW  = pix_count_bits(WIDTH, HEIGHT);
    localparam int CLW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int RW  = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam logic [CLW-1:0] COL_MAX = CLW'(WIDTH - 1);
    localparam logic [RW-1:0]  ROW_MAX = RW'(HEIGHT - 1);

    logic                  vs_q, vs_rise, take, line_end, frame_end, done;
    logic [CLW-1:0]        col, col_e;
    logic [RW-1:0]         row, row_e;
    logic [2:0]            bcnt, bcnt_e;
    logic [7:0]            sh, sh_nx;
    logic [CW-1:0]         acc, acc_e;
    logic                  wr_en, full, empty;
    fifo_entry_t           wr_entry, rd_entry;
    logic [$clog2(DEPTH):0] unused_level;
    logic                  unused_hsync;

    assign unused_hsync = sobel_hsync;

    // A vsync rising edge zeroes the frame state seen by the pixel arriving in that cycle
    always_comb begin
        vs_rise   = sobel_vsync && !vs_q;
        take      = sobel_valid && sobel_vsync;
        col_e     = vs_rise ? '0 : col;
        row_e     = vs_rise ? '0 : row;
        bcnt_e    = vs_rise ? '0 : bcnt;
        acc_e     = vs_rise ? '0 : acc;
        sh_nx     = {sh[6:0], sobel};
        line_end  = col_e == COL_MAX;
        frame_end = line_end && row_e == ROW_MAX;
        done      = take && (bcnt_e == 3'd7 || line_end);
    end

    // Pixel counters, shift register and per-frame edge accumulator
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            vs_q             <= 1'b0;
            col              <= '0;
            row              <= '0;
            bcnt             <= '0;
            sh               <= '0;
            acc              <= '0;
            edge_count       <= '0;
            edge_count_valid <= 1'b0;
        end else begin
            vs_q             <= sobel_vsync;
            edge_count_valid <= take && frame_end;
            if (take) begin
                col  <= line_end ? '0 : col_e + 1'b1;
                row  <= frame_end ? '0 : (line_end ? row_e + 1'b1 : row_e);
                bcnt <= done ? '0 : bcnt_e + 1'b1;
                sh   <= sh_nx;
                acc  <= frame_end ? '0 : acc_e + CW'(sobel);
                if (frame_end) edge_count <= acc_e + CW'(sobel);
            end else if (vs_rise) begin
                col  <= '0;
                row  <= '0;
                bcnt <= '0;
                acc  <= '0;
            end
        end
    end

    // Register the completed byte; the left shift zero-pads a short line-end byte
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wr_en    <= 1'b0;
            wr_entry <= '0;
        end else begin
            wr_en    <= done;
            wr_entry <= '{sof:  row_e == '0 && (col_e >> 3) == '0,
                           eol:  line_end,
                           eof:  frame_end,
                           data: sh_nx << (3'd7 - bcnt_e)};
        end
    end

    // Sticky drop flag, cleared at the start of each frame
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) overflow <= 1'b0;
        else       overflow <= vs_rise ? 1'b0 : overflow | (wr_en && full && !out_ready);
    end

    sync_fifo_fwft #(
        .WIDTH_BITS (ENTRY_BITS),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_p   (rst_p),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (out_ready),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (unused_level)
    );

    assign {out_sof, out_eol, out_eof, out_data} = rd_entry;
    assign out_valid = !empty;

endmodule

// File: tb/tb_sobel_byte_packer.sv
// tb_sobel_byte_packer: directed checks of packing, padding, markers, overflow, resync and reset
module tb_sobel_byte_packer;
    localparam int W = 12;
    localparam int H = 2;
    localparam int D = 4;

    logic       clk = 1'b0, rst_p = 1'b1;
    logic       sobel = 1'b0, sobel_valid = 1'b0, sobel_hsync = 1'b0, sobel_vsync = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_eol, out_eof, overflow, edge_count_valid;
    logic [4:0] edge_count;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    sobel_byte_packer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk              (clk),
        .rst_p            (rst_p),
        .sobel            (sobel),
        .sobel_valid      (sobel_valid),
        .sobel_hsync      (sobel_hsync),
        .sobel_vsync      (sobel_vsync),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sof          (out_sof),
        .out_eol          (out_eol),
        .out_eof          (out_eof),
        .overflow         (overflow),
        .edge_count       (edge_count),
        .edge_count_valid (edge_count_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic p);
        sobel       = p;
        sobel_valid = 1'b1;
        sobel_hsync = sobel_vsync;
        tick();
        sobel_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [7:0] d, input logic s, input logic e, input logic f);
        chk(tag, {out_valid, out_sof, out_eol, out_eof, out_data}, {1'b1, s, e, f, d});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic idle_out(input string tag);
        chk(tag, {out_valid, out_sof, out_eol, out_eof, out_data}, 12'h0);
    endtask

    task automatic drain_alt(input string pfx);
        head({pfx, "_b0"}, 8'hAA, 1'b1, 1'b0, 1'b0);
        head({pfx, "_b1"}, 8'hA0, 1'b0, 1'b1, 1'b0);
        head({pfx, "_b2"}, 8'hAA, 1'b0, 1'b0, 1'b0);
        head({pfx, "_b3"}, 8'hA0, 1'b0, 1'b1, 1'b1);
        idle_out({pfx, "_empty"});
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_out", {out_valid, out_sof, out_eol, out_eof, out_data, overflow, edge_count_valid}, 14'h0);
        chk("rst_cnt", edge_count, 5'd0);
        rst_p       = 1'b0;
        sobel_vsync = 1'b1;
        tick();

        // padding frame: each line 1,0,1,0,... gives AA then zero-padded A0
        for (int i = 0; i < 8; i++) send(~i[0]);
        chk("lat_e0", out_valid, 1'b0);
        tick();
        chk("lat_e1", out_valid, 1'b1);
        for (int i = 8; i < W * H; i++) send(~i[0]);
        chk("pad_ec", {edge_count_valid, edge_count}, {1'b1, 5'd12});
        tick();
        chk("pad_ecv_drop", edge_count_valid, 1'b0);
        drain_alt("pad");

        // same frame with a gap after every pixel
        for (int i = 0; i < 8; i++) begin
            send(~i[0]);
            if (i < 7) tick();
        end
        chk("gap_e0", out_valid, 1'b0);
        tick();
        chk("gap_e1", out_valid, 1'b1);
        for (int i = 8; i < W * H; i++) begin
            send(~i[0]);
            tick();
        end
        chk("gap_ec", edge_count, 5'd12);
        drain_alt("gap");

        // backpressure: two all-ones frames into a 4-entry FIFO
        for (int i = 0; i < 32; i++) send(1'b1);
        chk("ovf_pre", overflow, 1'b0);
        send(1'b1);
        chk("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 15; i++) send(1'b1);
        tick();
        chk("bp_ec", edge_count, 5'd24);
        head("bp_b0", 8'hFF, 1'b1, 1'b0, 1'b0);
        head("bp_b1", 8'hF0, 1'b0, 1'b1, 1'b0);
        head("bp_b2", 8'hFF, 1'b0, 1'b0, 1'b0);
        head("bp_b3", 8'hF0, 1'b0, 1'b1, 1'b1);
        idle_out("bp_empty");
        chk("ovf_sticky", overflow, 1'b1);

        // resync: partial line, ignored pixels with vsync low, then a fresh frame
        for (int i = 0; i < 4; i++) send(1'b1);
        chk("rs_partial", out_valid, 1'b0);
        sobel_vsync = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1);
        tick();
        chk("rs_ignored", out_valid, 1'b0);
        sobel_vsync = 1'b1;
        tick();
        chk("rs_ovf_clr", overflow, 1'b0);
        for (int i = 0; i < W * H; i++) send(~i[0]);
        chk("rs_ec", {edge_count_valid, edge_count}, {1'b1, 5'd12});
        tick();
        drain_alt("rs");

        // asynchronous reset mid-frame
        for (int i = 0; i < 10; i++) send(1'b1);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst_p = 1'b1;
        #1;
        idle_out("rst_async_out");
        chk("rst_async_misc", {overflow, edge_count_valid, edge_count}, 7'h0);
        tick();
        rst_p = 1'b0;
        tick();
        idle_out("rst_held_empty");

        // full frame after reset, then a write that meets a pop while full
        for (int i = 0; i < W * H; i++) send(1'b1);
        tick();
        chk("post_rst_ec", edge_count, 5'd24);
        for (int i = 0; i < 8; i++) send(1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rw_full_ovf", overflow, 1'b0);
        head("rw_b1", 8'hF0, 1'b0, 1'b1, 1'b0);
        head("rw_b2", 8'hFF, 1'b0, 1'b0, 1'b0);
        head("rw_b3", 8'hF0, 1'b0, 1'b1, 1'b1);
        head("rw_b4", 8'hFF, 1'b1, 1'b0, 1'b0);
        idle_out("rw_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
